// File: rtl/muxn_arb.sv
// muxn_arb: CHANNELS-input, WIDTH-bit registered multiplexer with
// per-channel valid/ready handshakes and a one-entry output register.
//
// Selection is either forced (mux_mode=1, channel mux_sel) or arbitrated
// among the valid channels (mux_mode=0).
//
// Build option:
//   MUXN_ARB_RR_EN  defined   -> arbitrated mode is round-robin from rr_ptr
//                   undefined -> arbitrated mode is fixed priority (lowest
//                                index wins) and rr_ptr does not exist
//
// Ports:
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   mux_in         packed channel data, channel i at [i*WIDTH +: WIDTH]
//   mux_in_valid   per-channel valid
//   mux_in_ready   per-channel accept (combinational)
//   mux_mode       0 = arbitrated, 1 = forced select
//   mux_sel        channel index used in forced mode
//   mux_out        registered output data
//   mux_out_ch     channel that produced mux_out
//   mux_out_valid  mux_out holds unconsumed data
//   mux_out_ready  consumer accepts mux_out
module muxn_arb #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] mux_in,
    input  logic [CHANNELS-1:0]       mux_in_valid,
    output logic [CHANNELS-1:0]       mux_in_ready,
    input  logic                      mux_mode,
    input  logic [SEL_W-1:0]          mux_sel,
    output logic [WIDTH-1:0]          mux_out,
    output logic [SEL_W-1:0]          mux_out_ch,
    output logic                      mux_out_valid,
    input  logic                      mux_out_ready
);

    logic             can_accept;
    logic             gnt_any;
    logic [SEL_W-1:0] gnt_idx;
    logic             xfer;
    int               start;

`ifdef MUXN_ARB_RR_EN
    logic [SEL_W-1:0] rr_ptr;
    assign start = int'(rr_ptr);
`else
    assign start = 0;
`endif

    // One-entry buffer: a new word may enter when empty or when the
    // current word is being drained in the same cycle.
    assign can_accept = !mux_out_valid || mux_out_ready;

    always_comb begin
        int idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (mux_mode) begin
            // Out-of-range mux_sel matches no channel, so no grant.
            for (int i = 0; i < CHANNELS; i++) begin
                if (int'(mux_sel) == i && mux_in_valid[i]) begin
                    gnt_any = 1'b1;
                    gnt_idx = SEL_W'(i);
                end
            end
        end else begin
            // Scan from the start pointer, wrapping, first valid wins.
            for (int k = 0; k < CHANNELS; k++) begin
                idx = start + k;
                if (idx >= CHANNELS) idx = idx - CHANNELS;
                if (!gnt_any && mux_in_valid[idx]) begin
                    gnt_any = 1'b1;
                    gnt_idx = SEL_W'(idx);
                end
            end
        end
    end

    // Ready is suppressed while reset is asserted so no producer sees an
    // acknowledge for a word that the reset will throw away.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            mux_in_ready[i] = gnt_any && (int'(gnt_idx) == i) && can_accept && rst_n;
        end
    end

    assign xfer = gnt_any && can_accept;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mux_out       <= '0;
            mux_out_ch    <= '0;
            mux_out_valid <= 1'b0;
`ifdef MUXN_ARB_RR_EN
            rr_ptr        <= '0;
`endif
        end else if (xfer) begin
            mux_out       <= mux_in[int'(gnt_idx)*WIDTH +: WIDTH];
            mux_out_ch    <= gnt_idx;
            mux_out_valid <= 1'b1;
`ifdef MUXN_ARB_RR_EN
            // Pointer moves past the winner in both modes.
            rr_ptr        <= (int'(gnt_idx) == CHANNELS-1) ? '0 : gnt_idx + 1'b1;
`endif
        end else if (mux_out_ready) begin
            mux_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_muxn_arb.sv
module tb_muxn_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    // 4-channel instance
    logic [15:0] in4;
    logic [3:0]  v4, r4;
    logic        mode4, ordy4, oval4;
    logic [1:0]  sel4, och4;
    logic [3:0]  out4;
    // 3-channel instance (out-of-range select)
    logic [11:0] in3;
    logic [2:0]  v3, r3;
    logic        mode3, ordy3, oval3;
    logic [1:0]  sel3, och3;
    logic [3:0]  out3;

    int checks = 0;
    int passes = 0;

    // reference model state (4-channel instance)
    int m_valid, m_out, m_ch, m_rr;

    always #5 clk = ~clk;

    muxn_arb #(.WIDTH(4), .CHANNELS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .mux_in(in4), .mux_in_valid(v4),
        .mux_in_ready(r4), .mux_mode(mode4), .mux_sel(sel4),
        .mux_out(out4), .mux_out_ch(och4), .mux_out_valid(oval4),
        .mux_out_ready(ordy4));

    muxn_arb #(.WIDTH(4), .CHANNELS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .mux_in(in3), .mux_in_valid(v3),
        .mux_in_ready(r3), .mux_mode(mode3), .mux_sel(sel3),
        .mux_out(out3), .mux_out_ch(och3), .mux_out_valid(oval3),
        .mux_out_ready(ordy3));

    // Which channel the rules say wins, or -1 for none.
    function automatic int ref_grant(logic [3:0] v, logic mode, int sel, int rr);
        int start;
        if (mode) return (sel < 4 && v[sel]) ? sel : -1;
`ifdef MUXN_ARB_RR_EN
        start = rr;
`else
        start = 0;
`endif
        for (int k = 0; k < 4; k++)
            if (v[(start + k) % 4]) return (start + k) % 4;
        return -1;
    endfunction

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; in4 = 16'h4321; v4 = 4'hF; mode4 = 1'b0; sel4 = 2'd0; ordy4 = 1'b1;
        in3 = 12'h0; v3 = 3'b0; mode3 = 1'b0; sel3 = 2'd0; ordy3 = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (r4 !== 4'b0) $display("FAIL reset_ready got=%b exp=0000", r4); else passes++;
            edge_wait();
            checks++;
            if (oval4 !== 1'b0 || out4 !== 4'h0 || och4 !== 2'd0)
                $display("FAIL reset_out got v=%b d=%h ch=%0d exp v=0 d=0 ch=0", oval4, out4, och4);
            else passes++;
            @(negedge clk);
        end
        rst_n = 1'b1;
        #1;
        checks++; if (r4 !== 4'b0001) $display("FAIL first_ready got=%b exp=0001", r4); else passes++;
        edge_wait();
        checks++;
        if (oval4 !== 1'b1 || out4 !== 4'h1 || och4 !== 2'd0)
            $display("FAIL first_xfer got v=%b d=%h ch=%0d exp v=1 d=1 ch=0", oval4, out4, och4);
        else passes++;
    endtask

    task automatic test_forced();
        @(negedge clk);
        mode4 = 1'b1; sel4 = 2'd2; in4 = 16'h4321; v4 = 4'hF; ordy4 = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (r4 !== 4'b0100) $display("FAIL forced_ready got=%b exp=0100", r4); else passes++;
            edge_wait();
            checks++;
            if (oval4 !== 1'b1 || out4 !== 4'h3 || och4 !== 2'd2)
                $display("FAIL forced_out got v=%b d=%h ch=%0d exp v=1 d=3 ch=2", oval4, out4, och4);
            else passes++;
            @(negedge clk);
        end
    endtask

    task automatic test_arb();
        int exp_all[5] = '{0, 1, 2, 3, 0};
`ifdef MUXN_ARB_RR_EN
        int exp_13[4] = '{1, 3, 1, 3};
`else
        int exp_13[4] = '{1, 1, 1, 1};
`endif
        @(negedge clk);
        rst_n = 1'b0;
        edge_wait();
        @(negedge clk);
        rst_n = 1'b1; mode4 = 1'b0; v4 = 4'hF; in4 = 16'h4321; ordy4 = 1'b1;
`ifdef MUXN_ARB_RR_EN
        for (int c = 0; c < 5; c++) begin
            edge_wait();
            checks++;
            if (int'(och4) != exp_all[c] || int'(out4) != exp_all[c] + 1)
                $display("FAIL rr_all[%0d] got ch=%0d d=%h exp ch=%0d", c, och4, out4, exp_all[c]);
            else passes++;
        end
`else
        for (int c = 0; c < 5; c++) begin
            edge_wait();
            checks++;
            if (och4 !== 2'd0) $display("FAIL fp_all[%0d] got ch=%0d exp ch=0", c, och4);
            else passes++;
        end
`endif
        @(negedge clk);
        v4 = 4'b1010;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (r4 !== (4'b0001 << exp_13[c]))
                $display("FAIL arb13_ready[%0d] got=%b exp ch=%0d", c, r4, exp_13[c]);
            else passes++;
            edge_wait();
            checks++;
            if (int'(och4) != exp_13[c]) $display("FAIL arb13_ch[%0d] got=%0d exp=%0d", c, och4, exp_13[c]);
            else passes++;
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        v4 = 4'b0; ordy4 = 1'b1;
        edge_wait();
        @(negedge clk);
        mode4 = 1'b1; sel4 = 2'd2; v4 = 4'b0100; in4 = 16'h0A00; ordy4 = 1'b0;
        edge_wait();
        checks++;
        if (oval4 !== 1'b1 || out4 !== 4'hA) $display("FAIL bp_fill got v=%b d=%h exp v=1 d=a", oval4, out4);
        else passes++;
        @(negedge clk);
        in4 = 16'h0500;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (r4 !== 4'b0) $display("FAIL bp_ready got=%b exp=0000", r4); else passes++;
            edge_wait();
            checks++;
            if (oval4 !== 1'b1 || out4 !== 4'hA || och4 !== 2'd2)
                $display("FAIL bp_hold got v=%b d=%h ch=%0d exp v=1 d=a ch=2", oval4, out4, och4);
            else passes++;
            @(negedge clk);
        end
        ordy4 = 1'b1;
        #1;
        checks++; if (r4 !== 4'b0100) $display("FAIL bp_release_ready got=%b exp=0100", r4); else passes++;
        edge_wait();
        checks++;
        if (oval4 !== 1'b1 || out4 !== 4'h5) $display("FAIL bp_release got v=%b d=%h exp v=1 d=5", oval4, out4);
        else passes++;
    endtask

    task automatic test_edge();
        // reset while full discards the word
        @(negedge clk);
        mode4 = 1'b1; sel4 = 2'd1; v4 = 4'b0010; in4 = 16'h00E0; ordy4 = 1'b0;
        edge_wait();
        @(negedge clk);
        rst_n = 1'b0;
        edge_wait();
        checks++;
        if (oval4 !== 1'b0 || out4 !== 4'h0) $display("FAIL reset_full got v=%b d=%h exp v=0 d=0", oval4, out4);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1; v4 = 4'b0;
        // out-of-range select on the 3-channel instance
        mode3 = 1'b1; sel3 = 2'd0; v3 = 3'b001; in3 = 12'h007; ordy3 = 1'b0;
        edge_wait();
        checks++;
        if (oval3 !== 1'b1 || out3 !== 4'h7) $display("FAIL c3_fill got v=%b d=%h exp v=1 d=7", oval3, out3);
        else passes++;
        @(negedge clk);
        sel3 = 2'd3; v3 = 3'b111; ordy3 = 1'b1;
        #1;
        checks++; if (r3 !== 3'b0) $display("FAIL c3_sel_oob_ready got=%b exp=000", r3); else passes++;
        edge_wait();
        checks++;
        if (oval3 !== 1'b0 || out3 !== 4'h7) $display("FAIL c3_drain got v=%b d=%h exp v=0 d=7", oval3, out3);
        else passes++;
    endtask

    task automatic test_random();
        int g, can;
        logic [3:0] er;
        @(negedge clk);
        rst_n = 1'b0; v4 = 4'b0;
        edge_wait();
        m_valid = 0; m_out = 0; m_ch = 0; m_rr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 300; c++) begin
            in4 = 16'($urandom); v4 = 4'($urandom); mode4 = ($urandom_range(0, 3) == 0);
            sel4 = 2'($urandom); ordy4 = ($urandom_range(0, 3) != 0);
            #1;
            g = ref_grant(v4, mode4, int'(sel4), m_rr);
            can = (m_valid == 0 || ordy4) ? 1 : 0;
            er = (g >= 0 && can == 1) ? (4'b0001 << g) : 4'b0;
            checks++; if (r4 !== er) $display("FAIL rand_ready[%0d] got=%b exp=%b", c, r4, er); else passes++;
            edge_wait();
            if (g >= 0 && can == 1) begin
                m_out = int'(in4[g*4 +: 4]); m_ch = g; m_valid = 1; m_rr = (g + 1) % 4;
            end else if (ordy4) m_valid = 0;
            checks++;
            if (int'(oval4) != m_valid || int'(out4) != m_out || int'(och4) != m_ch)
                $display("FAIL rand_out[%0d] got v=%b d=%h ch=%0d exp v=%0d d=%h ch=%0d",
                         c, oval4, out4, och4, m_valid, m_out, m_ch);
            else passes++;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_forced();
        test_arb();
        test_backpressure();
        test_edge();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
